// File: rtl/multich_decimator_pkg.sv
// Shared types and limits for the multichannel decimator.
// Works with or without DECIMATOR_ACCUM_EN.
package multich_decimator_pkg;

    localparam int DECIM_MIN = 2;
    localparam int DECIM_MAX = 256;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic bit decim_legal(input int decim);
        return (decim >= DECIM_MIN) && (decim <= DECIM_MAX);
    endfunction

endpackage

// File: rtl/multich_decimator_chbank.sv
// Per-channel window state: counter, sticky last flag and, when DECIMATOR_ACCUM_EN
// is defined, the running accumulator. Presents the dump decision for the addressed channel.
module multich_decimator_chbank
    import multich_decimator_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int CH_W   = 3,
    parameter int DECIM  = 5,
    parameter int OUT_W  = DATA_W + $clog2(DECIM)
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   ch,
    input  logic [DATA_W-1:0] sample,
    input  logic              last,
    output logic              dump,
    output logic [OUT_W-1:0]  result,
    output logic              res_last
);

    localparam int NCH   = 2 ** CH_W;
    localparam int CNT_W = $clog2(DECIM);

    logic [CNT_W-1:0]  cnt_q [NCH];
    logic [CNT_W-1:0]  cnt_d [NCH];
    logic [NCH-1:0]    sticky_q;
    logic [NCH-1:0]    sticky_d;
    logic signed [OUT_W-1:0] sample_ext;
    logic signed [OUT_W-1:0] window_val;

    assign sample_ext = OUT_W'($signed(sample));
    assign dump       = (cnt_q[ch] == CNT_W'(DECIM - 1)) || last;
    assign res_last   = last || sticky_q[ch];
    assign result     = window_val;

`ifdef DECIMATOR_ACCUM_EN
    logic signed [OUT_W-1:0] acc_q [NCH];
    logic signed [OUT_W-1:0] acc_d [NCH];

    // Sum of up to DECIM samples always fits OUT_W bits, so no saturation is needed.
    assign window_val = acc_q[ch] + sample_ext;

    always_comb begin
        acc_d = acc_q;
        if (wr_en) begin
            acc_d[ch] = dump ? '0 : window_val;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign window_val = sample_ext;
`endif

    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (wr_en) begin
            if (dump) begin
                cnt_d[ch]    = '0;
                sticky_d[ch] = 1'b0;
            end else begin
                cnt_d[ch]    = cnt_q[ch] + CNT_W'(1);
                sticky_d[ch] = sticky_q[ch] | last;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            sticky_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: rtl/multich_decimator.sv
// Multichannel decimator with a single-entry registered output stage.
// Define DECIMATOR_ACCUM_EN to output window sums instead of the last sample of each window.
module multich_decimator
    import multich_decimator_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int CH_W   = 3,
    parameter int DECIM  = 5,
    localparam int OUT_W = DATA_W + $clog2(DECIM)
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_areset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [CH_W-1:0]   s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic [OUT_W-1:0]  m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [CH_W-1:0]   m_axis_tuser,
    output logic              m_axis_tlast
);

    if (!decim_legal(DECIM)) begin : g_decim_range
        $error("multich_decimator: DECIM must be within 2..256");
    end

    out_state_t       state_q, state_d;
    logic [OUT_W-1:0] tdata_q, tdata_d;
    logic [CH_W-1:0]  tuser_q, tuser_d;
    logic             tlast_q, tlast_d;

    logic             accept;
    logic             dump;
    logic             dump_fire;
    logic [OUT_W-1:0] result;
    logic             res_last;

    assign m_axis_tvalid = (state_q == OUT_FULL);
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign dump_fire     = accept && dump;

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;

    multich_decimator_chbank #(
        .DATA_W (DATA_W),
        .CH_W   (CH_W),
        .DECIM  (DECIM),
        .OUT_W  (OUT_W)
    ) u_chbank (
        .clk_sys  (s_axis_aclk),
        .rst      (s_axis_areset),
        .wr_en    (accept),
        .ch       (s_axis_tuser),
        .sample   (s_axis_tdata),
        .last     (s_axis_tlast),
        .dump     (dump),
        .result   (result),
        .res_last (res_last)
    );

    // A dump can only fire while the output is empty or being drained this cycle,
    // so loading on dump_fire never overwrites an unaccepted result.
    always_comb begin
        state_d = state_q;
        tdata_d = tdata_q;
        tuser_d = tuser_q;
        tlast_d = tlast_q;
        case (state_q)
            OUT_EMPTY: begin
                if (dump_fire) state_d = OUT_FULL;
            end
            OUT_FULL: begin
                if (m_axis_tready) state_d = dump_fire ? OUT_FULL : OUT_EMPTY;
            end
            default: state_d = OUT_EMPTY;
        endcase
        if (dump_fire) begin
            tdata_d = result;
            tuser_d = s_axis_tuser;
            tlast_d = res_last;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q <= OUT_EMPTY;
            tdata_q <= '0;
            tuser_q <= '0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tdata_q <= tdata_d;
            tuser_q <= tuser_d;
            tlast_q <= tlast_d;
        end
    end

endmodule

// File: tb/tb_multich_decimator.sv
// Directed bench for multich_decimator (DATA_W=24, CH_W=3, DECIM=5).
// Expected values follow DECIMATOR_ACCUM_EN: window sums when defined, last sample otherwise.
module tb_multich_decimator;

    localparam int DATA_W = 24;
    localparam int CH_W   = 3;
    localparam int DECIM  = 5;
    localparam int OUT_W  = 27;

`ifdef DECIMATOR_ACCUM_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [CH_W-1:0]   s_tuser;
    logic              s_tlast;
    logic [OUT_W-1:0]  m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [CH_W-1:0]   m_tuser;
    logic              m_tlast;

    always #5 clk = ~clk;

    multich_decimator #(
        .DATA_W (DATA_W),
        .CH_W   (CH_W),
        .DECIM  (DECIM)
    ) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast)
    );

    typedef struct {
        longint data;
        int     user;
        bit     last;
    } beat_t;

    beat_t out_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs only change 1 ns after a rising edge, so a handshake seen at the
    // falling edge is the one that completes on the next rising edge.
    always @(negedge clk) begin : mon
        beat_t b;
        if (!rst && m_tvalid && m_tready) begin
            b.data = longint'($signed(m_tdata));
            b.user = int'(m_tuser);
            b.last = m_tlast;
            out_q.push_back(b);
        end
    end

    task automatic send(input int ch, input longint d, input bit last);
        bit rdy;
        int n;
        s_tvalid = 1'b1;
        s_tdata  = DATA_W'(d);
        s_tuser  = CH_W'(ch);
        s_tlast  = last;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = s_tready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                check_val("send_timeout", 0, 1);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input longint data, input int user, input bit last);
        beat_t b;
        int n;
        n = 0;
        while (out_q.size() == 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_q.size() == 0) begin
            check_val({tag, "_timeout"}, 0, 1);
        end else begin
            b = out_q.pop_front();
            check_val({tag, "_data"}, b.data, data);
            check_val({tag, "_user"}, b.user, user);
            check_val({tag, "_last"}, b.last, last);
        end
    endtask

    initial begin
        logic [OUT_W-1:0] snap_data;
        logic [CH_W-1:0]  snap_user;
        logic             snap_last;
        int               bad_rdy;
        int               changes;

        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        check_val("rst_tvalid", m_tvalid, 0);
        check_val("rst_tdata",  m_tdata, 0);
        check_val("rst_tuser",  m_tuser, 0);
        check_val("rst_tlast",  m_tlast, 0);
        check_val("rst_tready", s_tready, 1);

        // ch2: 1..5, output one cycle after the fifth beat
        for (int i = 1; i <= 4; i++) send(2, i, 1'b0);
        check_val("w1_no_early", m_tvalid, 0);
        send(2, 5, 1'b0);
        check_val("w1_tvalid", m_tvalid, 1);
        check_val("w1_tdata",  longint'($signed(m_tdata)), ACC ? 15 : 5);
        expect_out("w1", ACC ? 15 : 5, 2, 1'b0);

        // interleaved ch0 (+100) and ch7 (-1)
        for (int i = 0; i < 10; i++) begin
            send(0, 100, 1'b0);
            send(7, -1, 1'b0);
        end
        expect_out("il_0a", ACC ? 500 : 100, 0, 1'b0);
        expect_out("il_7a", ACC ? -5 : -1, 7, 1'b0);
        expect_out("il_0b", ACC ? 500 : 100, 0, 1'b0);
        expect_out("il_7b", ACC ? -5 : -1, 7, 1'b0);

        // tlast flushes a partial window; the next window restarts at count 0
        send(1, 7, 1'b0);
        send(1, 8, 1'b1);
        expect_out("flush", ACC ? 15 : 8, 1, 1'b1);
        for (int i = 0; i < 4; i++) send(1, 1, 1'b0);
        check_val("flush_restart_no_early", m_tvalid, 0);
        send(1, 1, 1'b0);
        expect_out("flush_next", ACC ? 5 : 1, 1, 1'b0);

        // back-to-back single-sample frames: no bubble between outputs
        send(5, 9, 1'b1);
        check_val("b2b_first", longint'($signed(m_tdata)), 9);
        send(5, -3, 1'b1);
        check_val("b2b_tvalid", m_tvalid, 1);
        check_val("b2b_second", longint'($signed(m_tdata)), -3);
        expect_out("b2b_a", 9, 5, 1'b1);
        expect_out("b2b_b", -3, 5, 1'b1);

        // 20-cycle output stall with a new beat waiting
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) send(3, 3, 1'b0);
        check_val("stall_tvalid", m_tvalid, 1);
        s_tvalid  = 1'b1;
        s_tdata   = DATA_W'(4);
        s_tuser   = CH_W'(3);
        s_tlast   = 1'b0;
        snap_data = m_tdata;
        snap_user = m_tuser;
        snap_last = m_tlast;
        bad_rdy   = 0;
        changes   = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_tready !== 1'b0) bad_rdy++;
            if (m_tdata !== snap_data || m_tuser !== snap_user ||
                m_tlast !== snap_last || m_tvalid !== 1'b1) changes++;
        end
        check_val("stall_tready", bad_rdy, 0);
        check_val("stall_stable", changes, 0);
        check_val("stall_no_out", out_q.size(), 0);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) send(3, 4, 1'b0);
        expect_out("stall_a", ACC ? 15 : 3, 3, 1'b0);
        expect_out("stall_b", ACC ? 20 : 4, 3, 1'b0);

        // reset mid-operation: partial ch4 window and a pending ch6 output are dropped
        for (int i = 0; i < 3; i++) send(4, 7, 1'b0);
        m_tready = 1'b0;
        send(6, 1, 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_tready = 1'b1;
        check_val("mrst_tvalid", m_tvalid, 0);
        check_val("mrst_tready", s_tready, 1);
        check_val("mrst_tdata",  m_tdata, 0);
        check_val("mrst_no_out", out_q.size(), 0);
        for (int i = 0; i < 5; i++) send(4, 2, 1'b0);
        expect_out("mrst_win", ACC ? 10 : 2, 4, 1'b0);

        // most negative input, sign extension to OUT_W
        for (int i = 1; i <= 5; i++) send(6, i, 1'b0);
        for (int i = 0; i < 5; i++) send(6, -8388608, 1'b0);
        expect_out("neg_a", ACC ? 15 : 5, 6, 1'b0);
        expect_out("neg_b", ACC ? -41943040 : -8388608, 6, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check_val("tail_empty", out_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multich_decimator.md
MULTICH_DECIMATOR -- requirements
Module: multich_decimator

Interface
REQ-001 SHALL have parameter DATA_W, default 24, giving the signed input sample width.
REQ-002 SHALL have parameter CH_W, default 3, giving the channel index width; NCH = 2**CH_W channels.
REQ-003 SHALL have parameter DECIM, default 5, giving the decimation factor; legal range is 2..256, and elaboration SHALL fail outside it.
REQ-004 SHALL have localparam OUT_W = DATA_W + $clog2(DECIM), giving the signed output width.
REQ-005 SHALL have port s_axis_aclk, input, width 1: the only clock.
REQ-006 SHALL have port s_axis_areset, input, width 1: synchronous, active-high reset.
REQ-007 SHALL have port s_axis_tdata, input, width DATA_W: signed input sample.
REQ-008 SHALL have port s_axis_tvalid, input, width 1: input valid.
REQ-009 SHALL have port s_axis_tready, output, width 1: input ready.
REQ-010 SHALL have port s_axis_tuser, input, width CH_W: input channel index.
REQ-011 SHALL have port s_axis_tlast, input, width 1: end of frame for that channel.
REQ-012 SHALL have port m_axis_tdata, output, width OUT_W: signed decimated sample.
REQ-013 SHALL have port m_axis_tvalid, output, width 1: output valid.
REQ-014 SHALL have port m_axis_tready, input, width 1: output ready.
REQ-015 SHALL have port m_axis_tuser, output, width CH_W: channel of the output sample.
REQ-016 SHALL have port m_axis_tlast, output, width 1: frame end for that channel.

Function
REQ-017 SHALL keep, per channel, a window counter (0..DECIM-1), an OUT_W accumulator and a sticky last flag, all independent across channels.
REQ-018 SHALL accept an input beat only when s_axis_tvalid and s_axis_tready are both high; s_axis_tready SHALL equal !m_axis_tvalid | m_axis_tready.
REQ-019 SHALL, on each accepted beat, advance the channel's counter; the beat is a dump when the counter equals DECIM-1 or s_axis_tlast is high.
REQ-020 SHALL, on a non-dump beat, update the channel state only, with no output.
REQ-021 SHALL, on a dump beat, load the output register on the next edge (latency 1 cycle), clear the channel's counter, accumulator and sticky flag, and leave other channels untouched.
REQ-022 SHALL drive m_axis_tlast = 1 for a dump caused by s_axis_tlast or by a sticky flag set in that window; a tlast dump SHALL flush a partial window (fewer than DECIM samples).
REQ-023 SHALL hold m_axis_tvalid until m_axis_tready; m_axis_tdata, m_axis_tuser and m_axis_tlast SHALL stay stable while stalled.
REQ-024 SHALL, when the output is accepted and a new dump occurs in the same cycle, load the new result with no bubble.
REQ-025 SHALL use a two-state output FSM: OUT_EMPTY goes to OUT_FULL on a dump; OUT_FULL goes to OUT_EMPTY on a handshake without a dump; OUT_FULL stays OUT_FULL on a handshake with a dump.

Reset
REQ-026 SHALL, while s_axis_areset is high, clear all counters, accumulators, sticky flags, m_axis_tvalid, m_axis_tdata, m_axis_tuser and m_axis_tlast to 0, and drive s_axis_tready = 1 from the first cycle after release.
REQ-027 SHALL, on reset mid-operation, discard partial windows and any pending output with no residue.

Configuration
REQ-028 SHALL, with DECIMATOR_ACCUM_EN defined, output the signed sum of the window's samples (inputs sign-extended to OUT_W); the sum can never overflow.
REQ-029 SHALL, without DECIMATOR_ACCUM_EN, output the last sample of the window sign-extended to OUT_W, omit the accumulator storage, and keep identical handshake and timing.

Structure
REQ-030 SHALL place out_state_t (OUT_EMPTY/OUT_FULL) and the DECIM-range limits in package multich_decimator_pkg.
REQ-031 SHALL implement the per-channel counter/accumulator/sticky storage in sub-module multich_decimator_chbank.

Verification
REQ-032 SHALL verify, with ACCUM_EN, DECIM=5, ch 2 samples 1,2,3,4,5 and m_axis_tready=1: one output of 15, tuser=2, tlast=0, one cycle after the 5th beat.
REQ-033 SHALL verify interleaved ch0 = 10 x (+100) and ch7 = 10 x (-1): two outputs of 500 for ch0 and two of -5 for ch7, in dump order.
REQ-034 SHALL verify ch1 samples 7,8 with tlast on 8: an output of 15 with tlast=1, and a subsequent window starting from count 0.
REQ-035 SHALL verify m_axis_tready=0 for 20 cycles with a pending output: s_axis_tready=0, the output stays stable, and there is no loss once released.
REQ-036 SHALL verify reset asserted after 3 ch4 samples, then 5 samples of 2: output 10, not including the earlier partial sum.
REQ-037 SHALL verify, without ACCUM_EN, samples 1..5 followed by -8388608 x 5: outputs 5 and -8388608 sign-extended.
